// File: rtl/ram_stream_reader.sv
// ram_stream_reader: sequential read master for a single-port word RAM.
// A start command loads a base address and a word count. The block then walks
// consecutive addresses, wrapping modulo 2^ADDRESS_WIDTH, and streams each word
// out on a valid/ready interface. Without back-pressure it sends one word per cycle.
// Optional clear-on-read: define RAM_STREAM_READER_CLEAR_EN to zero every word
// at the same edge that fetches it.
module ram_stream_reader #(
    parameter int BUS_WIDTH     = 8,
    parameter int ADDRESS_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH-1:0] base,
    input  logic [ADDRESS_WIDTH:0]   len,
    output logic                     busy,
    output logic                     done,
    output logic [ADDRESS_WIDTH-1:0] mem_ad,
    output logic                     mem_st,
    output logic [BUS_WIDTH-1:0]     mem_x,
    input  logic [BUS_WIDTH-1:0]     mem_o,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [BUS_WIDTH-1:0]     out_data,
    output logic                     out_last
);

    localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE = 1;
    localparam logic [ADDRESS_WIDTH:0]   REM_ZERO = '0;
    localparam logic [ADDRESS_WIDTH:0]   REM_ONE  = 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [ADDRESS_WIDTH:0]   remaining_q, remaining_d;
    logic [BUS_WIDTH-1:0]     data_q, data_d;
    logic                     valid_q, valid_d;
    logic                     last_q, last_d;
    logic                     fetch;

    // A new word may be loaded when the output register is empty or being consumed.
    assign fetch = !valid_q || out_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. start only matters in IDLE; len==0 goes straight to DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (len != REM_ZERO) ? RUN : DONE;
                end
            end
            RUN: begin
                if (fetch && (remaining_q == REM_ONE)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decoded from state. With clear-on-read, the RAM is written on every RUN fetch.
    always_comb begin
        busy  = (state_q == RUN) || (state_q == DRAIN);
        done  = (state_q == DONE);
        mem_x = '0;
`ifdef RAM_STREAM_READER_CLEAR_EN
        mem_st = rst_n && (state_q == RUN) && fetch;
`else
        mem_st = 1'b0;
`endif
    end

    // Datapath next values: address walk, word count and the output holding register.
    always_comb begin
        addr_d      = addr_q;
        remaining_d = remaining_q;
        data_d      = data_q;
        valid_d     = valid_q;
        last_d      = last_q;
        case (state_q)
            IDLE: begin
                if (start && (len != REM_ZERO)) begin
                    addr_d      = base;
                    remaining_d = len;
                end
            end
            RUN: begin
                if (fetch) begin
                    data_d      = mem_o;
                    valid_d     = 1'b1;
                    last_d      = (remaining_q == REM_ONE);
                    addr_d      = addr_q + ADDR_ONE;
                    remaining_d = remaining_q - REM_ONE;
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath registers. Reset clears everything, which also aborts a running block.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q      <= '0;
            remaining_q <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            last_q      <= last_d;
        end
    end

    assign mem_ad    = addr_q;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_last  = last_q;

endmodule
